mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-outstanding arbiter that shares the core's one memory port between the instruction-fetch requester and the load/store requester. It sits between the cpu core and umem, and owns the whole memory transaction:
- grant selection between the two requesters;
- byte-strobe generation from the access size;
- misalignment rejection;
- the valid/ready request handshake and the wait for the response;
- a response timeout.

## Interface
Parameters
- MAX_DATA_RUN, 4: consecutive data grants allowed while fetch is also requesting; range 1–15.
- TIMEOUT, 255: number of WAIT_RSP cycles before an error response; range 1–255.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held until granted.
- f_addr  in  32  fetch address; must be word aligned.
- f_gnt  out  1  fetch granted this cycle.
- f_rvalid  out  1  fetch response valid, one-cycle pulse.
- f_rdata  out  32  fetch response data.
- f_err  out  1  fetch error; qualified by f_rvalid.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as a misaligned access.
- d_addr  in  32  data address.
- d_wdata  in  32  store data; the value is in the low bits.
- d_gnt, d_rvalid, d_err  out  1 each  same meaning as the f_ versions, for the data requester.
- d_rdata  out  32  raw 32-bit memory word; the core does the lane extraction.
- m_valid  out  1  memory request valid.
- m_ready  in  1  memory accepts the request.
- m_we  out  1  write enable.
- m_addr  out  32  address with bits [1:0] forced to 0.
- m_wdata  out  32  lane-replicated write data.
- m_wstrb  out  4  byte strobes; 0 for reads.
- m_rvalid  in  1  memory response; also sent for writes as an acknowledge.
- m_rdata  in  32  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT_RSP, RESP.

IDLE
- f_gnt and d_gnt are combinational and can only be high in IDLE; at most one is high.
- Arbitration:
  - If only one requester is asserting, it wins.
  - If both are asserting, data wins unless run_cnt == MAX_DATA_RUN; in that case fetch wins.
- run_cnt (4-bit):
  - cleared on every fetch grant;
  - incremented on a data grant, saturating at MAX_DATA_RUN.
  - Data grants with no competing fetch request still increment run_cnt.
- On a grant, the request is latched into the payload registers and the owner is recorded.
  - Next state is ISSUE.
  - Exception: a misaligned data request goes to RESP with err = 1, rdata = 0, and no memory access.
- Misaligned means:
  - size 1 with addr[0] = 1;
  - size 2 with addr[1:0] ≠ 0;
  - size 3 at any address.
- Fetch address bits [1:0] are ignored; fetch is always a word read.
- Strobes and write data:
  - byte: m_wstrb = 1 << addr[1:0], m_wdata = {4{wdata[7:0]}};
  - half: m_wstrb = addr[1] ? 4'b1100 : 4'b0011, m_wdata = {2{wdata[15:0]}};
  - word: m_wstrb = 4'b1111, m_wdata = wdata.
  - Loads: m_wstrb = 0.

ISSUE
- m_valid = 1, with m_we, m_addr, m_wdata and m_wstrb held stable from the latched payload.
- When m_valid & m_ready, next state is WAIT_RSP and tmo_cnt is cleared.
- m_valid is never withdrawn before it is accepted.

WAIT_RSP
- m_rvalid: m_rdata is latched with err = 0 and the next state is RESP.
- Otherwise tmo_cnt increments. When tmo_cnt == TIMEOUT − 1 without a response, next state is RESP with err = 1 and rdata = 0.
- m_rvalid is ignored in every state except WAIT_RSP.
- A late response after a timeout is therefore dropped.

RESP
- Pulses the owner's rvalid for one cycle, with the latched rdata and err; the other requester's outputs stay 0.
- Next state is IDLE.

Reset
- Asserting reset at any time immediately clears everything:
  - state = IDLE, run_cnt = 0, tmo_cnt = 0;
  - all outputs = 0, including m_valid, busy, the rvalids, the rdatas, the errs and m_wstrb.
- An in-flight transaction is abandoned and no response is issued.
- Because grants are combinational, f_gnt and d_gnt may go high in the first IDLE cycle after reset is released.

## Timing
- All outputs except f_gnt and d_gnt are registered.
- Minimum latency, with m_ready already high and a one-cycle memory:
  - grant at cycle 0;
  - m_valid at cycle 1 (accepted);
  - m_rvalid at cycle 2;
  - requester rvalid at cycle 3;
  - next grant possible at cycle 4.
- Each additional cycle m_ready stays low adds one cycle; each additional cycle before m_rvalid adds one cycle.
- Misaligned rejection: grant at cycle 0, d_rvalid with d_err at cycle 1.
- Timeout: err response arrives TIMEOUT + 1 cycles after entering WAIT_RSP.
- If a requester drops its req in the same cycle it is granted, the grant still stands (the payload is already latched).

## Test plan
- Fetch only, f_addr = 0x100, memory returns 0x00000013 one cycle after acceptance.
  - Required: f_gnt at c0, m_valid at c1, f_rvalid with f_rdata = 0x00000013 and f_err = 0 at c3.
- Store byte: d_addr = 0x203, d_wdata = 0xAB.
  - Required: m_addr = 0x200, m_wstrb = 4'b1000, m_wdata = 0xABABABAB, d_rvalid after the acknowledge.
  - Repeat as a half-word store at 0x202: m_wstrb = 4'b1100.
- Both requesters held high continuously, MAX_DATA_RUN = 4.
  - Required grant order: D D D D F D D D D F.
- Misaligned word load at 0x1002.
  - Required: no m_valid; d_rvalid with d_err = 1 and d_rdata = 0 one cycle after the grant.
- Memory holds m_ready low for 5 cycles, then never responds, TIMEOUT = 8.
  - Required: m_valid stays stable for 6 cycles.
  - Required: d_rvalid with d_err = 1 after 9 WAIT_RSP-related cycles.
  - Required: a late m_rvalid is ignored.
- Assert reset while in WAIT_RSP.
  - Required: m_valid and busy low immediately; no rvalid ever issued.
  - Required: the next fetch after release is granted normally with run_cnt = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with a single
// outstanding transaction, byte-lane formatting, misalignment rejection and a response timeout.
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_e;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        owner_q, owner_d;
  logic        m_valid_q, m_valid_d, m_we_q, m_we_d, busy_q, busy_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic        f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic        f_err_q, f_err_d, d_err_q, d_err_d;
  logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic        gnt_f, gnt_d, d_misal;
  logic        resp_vld, resp_err;
  logic [31:0] resp_data;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobes(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Data keeps priority until it has used up its run while fetch is waiting.
  always_comb begin
    gnt_f = 1'b0;
    gnt_d = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (d_req && !(f_req && run_cnt_q == RUN_MAX)) gnt_d = 1'b1;
      else if (f_req)                                gnt_f = 1'b1;
    end
  end

  assign d_misal = misaligned(d_size, d_addr[1:0]);

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state_q)
      IDLE: begin
        if (gnt_f) begin
          run_cnt_d = '0;
          owner_d   = 1'b0;
          m_we_d    = 1'b0;
          m_addr_d  = f_addr & 32'hFFFF_FFFC;
          m_wdata_d = '0;
          m_wstrb_d = '0;
          state_d   = ISSUE;
        end else if (gnt_d) begin
          if (run_cnt_q < RUN_MAX) run_cnt_d = run_cnt_q + 4'd1;
          owner_d = 1'b1;
          if (d_misal) begin
            resp_vld = 1'b1;
            resp_err = 1'b1;
            state_d  = RESP;
          end else begin
            m_we_d    = d_we;
            m_addr_d  = d_addr & 32'hFFFF_FFFC;
            m_wdata_d = lane_data(d_size, d_wdata);
            m_wstrb_d = d_we ? byte_strobes(d_size, d_addr[1:0]) : 4'b0000;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (m_ready) begin
          tmo_cnt_d = '0;
          state_d   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (m_rvalid) begin
          resp_vld  = 1'b1;
          resp_data = m_rdata;
          state_d   = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_vld = 1'b1;
          resp_err = 1'b1;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    m_valid_d  = (state_d == ISSUE);
    busy_d     = (state_d != IDLE);
    f_rvalid_d = resp_vld && !owner_d;
    d_rvalid_d = resp_vld && owner_d;
    f_err_d    = f_rvalid_d && resp_err;
    d_err_d    = d_rvalid_d && resp_err;
    f_rdata_d  = f_rvalid_d ? resp_data : '0;
    d_rdata_d  = d_rvalid_d ? resp_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      owner_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      busy_q     <= 1'b0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      owner_q    <= owner_d;
      m_valid_q  <= m_valid_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      busy_q     <= busy_d;
      f_rvalid_q <= f_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      f_err_q    <= f_err_d;
      d_err_q    <= d_err_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_gnt    = gnt_f;
  assign d_gnt    = gnt_d;
  assign m_valid  = m_valid_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign busy     = busy_q;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_err    = f_err_q;
  assign d_err    = d_err_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
endmodule
